// File: rtl/de10_io_pkg.sv
// Shared constants and types for the DE10-Lite switch input path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package de10_io_pkg;

    localparam int unsigned SW_WIDTH      = 10;
    localparam int unsigned CLK_HZ        = 50000000;
    // 10 ms worth of board clock cycles
    localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;

    // Per-bit debounce state: either settled on sw_db, or counting a candidate level
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } bit_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stable-time FSM/counter, registered rise/fall pulses.
// Latency: sw_db follows a held raw level on the (DEBOUNCE_CYCLES+2)th edge after it is first sampled.
// Backpressure: none; free-running, pulses are one cycle wide and never held.
module debounce_bit
    import de10_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall,
    output logic edge_nxt
);

    // Count value on which the candidate level has been seen long enough
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    bit_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             db_q,    db_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    // Synchroniser inputs: raw pin is only ever read by the first stage
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
    end

    // Next-state logic: a differing level must persist unbroken or the count restarts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sync2_q != db_q) begin
                    state_d = PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PENDING: begin
                if (sync2_q == db_q) begin
                    // bounced back to the old level: drop the partial count
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    db_d    = sync2_q;
                    rise_d  = sync2_q;
                    fall_d  = ~sync2_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register: synchroniser, FSM, counter, debounced level and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_db    = db_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;
    // Pre-register edge indication so the parent can register a strobe aligned with the pulses
    assign edge_nxt = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH slide switches; emits clean levels, per-bit rise/fall pulses and an any-change strobe.
// Latency: DEBOUNCE_CYCLES+2 edges from first sample of a held level; pulses and strobe coincide with sw_db.
// Backpressure: none; outputs are single-cycle pulses consumers must catch when they occur.
module switch_debouncer
    import de10_io_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_change
);

    logic [WIDTH-1:0] edge_nxt;
    logic             change_q, change_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_bit (
                .clk      (clk),
                .rst_n    (rst_n),
                .sw_raw   (sw_raw[i]),
                .sw_db    (sw_db[i]),
                .sw_rise  (sw_rise[i]),
                .sw_fall  (sw_fall[i]),
                .edge_nxt (edge_nxt[i])
            );
        end
    endgenerate

    // One strobe for any number of simultaneous bit edges
    always_comb begin
        change_d = |edge_nxt;
    end

    // Strobe register, same edge as the per-bit pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_q <= 1'b0;
        end else begin
            change_q <= change_d;
        end
    end

    assign sw_change = change_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with a fast debounce time.
// Latency: n/a.
// Backpressure: n/a.
module tb_switch_debouncer;

    localparam int W  = 10;
    localparam int DC = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
    logic         sw_change;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_change (sw_change)
    );

    // Reference: raw level delayed two edges, then a run-length of consecutive
    // cycles it disagrees with the accepted level; a run of DC flips the level.
    logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
    logic         m_chg;
    int           run [W];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == DC) begin
                        m_db[i] = m_s2[i];
                        if (m_s2[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_chg = |(m_rise | m_fall);
            m_s2  = m_s1;
            m_s1  = sw_raw;
        end
    end

    logic [W-1:0] acc_rise, acc_fall;
    int           acc_chg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clr_acc();
        acc_rise = '0;
        acc_fall = '0;
        acc_chg  = 0;
    endtask

    // One clock: sample just after the edge, check against the model, accumulate pulses
    task automatic cyc();
        @(posedge clk);
        #1;
        chk("model", {1'b0, sw_db, sw_rise, sw_fall, sw_change},
                     {1'b0, m_db, m_rise, m_fall, m_chg});
        acc_rise |= sw_rise;
        acc_fall |= sw_fall;
        acc_chg  += int'(sw_change);
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    typedef struct {
        logic [W-1:0] raw;
        int           n;
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        int           chg;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [W-1:0] raw, input int n, input logic [W-1:0] db,
                                input logic [W-1:0] rise, input logic [W-1:0] fall, input int chg);
        vec_t v;
        v.raw = raw; v.n = n; v.db = db; v.rise = rise; v.fall = fall; v.chg = chg;
        return v;
    endfunction

    initial begin
        // raw, edges held, sw_db after, rise seen, fall seen, change count
        tbl[0]  = mk(10'h000, 8, 10'h000, 10'h000, 10'h000, 0);
        tbl[1]  = mk(10'h001, 5, 10'h000, 10'h000, 10'h000, 0);  // one edge short
        tbl[2]  = mk(10'h001, 1, 10'h001, 10'h001, 10'h000, 1);  // 6th edge accepts
        tbl[3]  = mk(10'h001, 4, 10'h001, 10'h000, 10'h000, 0);
        tbl[4]  = mk(10'h003, 3, 10'h001, 10'h000, 10'h000, 0);  // bit1 glitch, 3 samples
        tbl[5]  = mk(10'h001, 8, 10'h001, 10'h000, 10'h000, 0);
        tbl[6]  = mk(10'h005, 1, 10'h001, 10'h000, 10'h000, 0);  // bit2 chatter
        tbl[7]  = mk(10'h001, 1, 10'h001, 10'h000, 10'h000, 0);
        tbl[8]  = mk(10'h005, 1, 10'h001, 10'h000, 10'h000, 0);
        tbl[9]  = mk(10'h001, 1, 10'h001, 10'h000, 10'h000, 0);
        tbl[10] = mk(10'h005, 5, 10'h001, 10'h000, 10'h000, 0);
        tbl[11] = mk(10'h005, 1, 10'h005, 10'h004, 10'h000, 1);
        tbl[12] = mk(10'h001, 6, 10'h001, 10'h000, 10'h004, 1);
        tbl[13] = mk(10'h200, 6, 10'h200, 10'h200, 10'h001, 1);  // fall[0] + rise[9] together

        clr_acc();

        // Reset with all switches up: outputs held low
        rst_n  = 1'b0;
        sw_raw = 10'h3FF;
        #25;
        chk("rst_db",   32'(sw_db),     32'h0);
        chk("rst_rise", 32'(sw_rise),   32'h0);
        chk("rst_fall", 32'(sw_fall),   32'h0);
        chk("rst_chg",  32'(sw_change), 32'h0);
        hold(2);
        rst_n = 1'b1;
        hold(5);
        chk("rel_db_e5",  32'(sw_db), 32'h0);
        cyc();
        chk("rel_db_e6",   32'(sw_db),     32'h3FF);
        chk("rel_rise_e6", 32'(sw_rise),   32'h3FF);
        chk("rel_chg_e6",  32'(sw_change), 32'h1);
        cyc();
        chk("rel_rise_e7", 32'(sw_rise),   32'h0);
        chk("rel_chg_e7",  32'(sw_change), 32'h0);

        // Restart from all-zero for the table
        rst_n  = 1'b0;
        sw_raw = '0;
        cyc();
        rst_n = 1'b1;
        for (int t = 0; t < 14; t++) begin
            sw_raw = tbl[t].raw;
            clr_acc();
            hold(tbl[t].n);
            chk($sformatf("tbl%0d_db", t),   32'(sw_db),    32'(tbl[t].db));
            chk($sformatf("tbl%0d_rise", t), 32'(acc_rise), 32'(tbl[t].rise));
            chk($sformatf("tbl%0d_fall", t), 32'(acc_fall), 32'(tbl[t].fall));
            chk($sformatf("tbl%0d_chg", t),  32'(acc_chg),  32'(tbl[t].chg));
        end

        // Async reset while bit3 is mid-count
        sw_raw = 10'h208;
        hold(4);
        chk("mid_db_pre", 32'(sw_db), 32'h200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_db",   32'(sw_db),     32'h0);
        chk("async_rise", 32'(sw_rise),   32'h0);
        chk("async_fall", 32'(sw_fall),   32'h0);
        chk("async_chg",  32'(sw_change), 32'h0);
        cyc();
        rst_n = 1'b1;
        clr_acc();
        hold(5);
        chk("post_db_e5", 32'(sw_db), 32'h0);
        cyc();
        chk("post_db_e6",   32'(sw_db),     32'h208);
        chk("post_rise_e6", 32'(sw_rise),   32'h208);
        chk("post_chg_e6",  32'(sw_change), 32'h1);

        // Random switch activity against the model
        for (int c = 0; c < 800; c++) begin
            int idx;
            if ($urandom_range(0, 3) == 0) begin
                idx = int'($urandom_range(0, W - 1));
                sw_raw[idx] = ~sw_raw[idx];
            end
            if ($urandom_range(0, 40) == 0) begin
                sw_raw = W'($urandom);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-conditioning stage between the DE10-Lite slide switches (SW) and the combinational cores (mux/demux/decoder tops) that consume them.
- Synchronises each raw switch bit into the clock domain and debounces it with a per-bit stable-time counter.
- Outputs a clean level, plus one-cycle rise/fall pulses per bit and an any-change strobe, so downstream cores and LED logic never see metastable or bouncing inputs.

Parameters:
- WIDTH, 10, number of switch bits conditioned.
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised level must differ from sw_db before it is accepted. 500000 is 10 ms at 50 MHz. Legal range 2..2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width. Derived; never overridden.

Ports:
- clk  input  1  50 MHz board clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw, asynchronous switch levels.
- sw_db  output  WIDTH  debounced level.
- sw_rise  output  WIDTH  one-cycle pulse when sw_db[i] goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse when sw_db[i] goes 1->0.
- sw_change  output  1  one-cycle pulse, OR of all sw_rise | sw_fall bits.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n). Assertion takes effect immediately, independent of clk.
  - While rst_n=0: sync stages = 0, sw_db = 0, sw_rise = 0, sw_fall = 0, sw_change = 0, all counters = 0, all bit FSMs = STABLE.
  - Release is sampled on the next rising edge.
- Synchroniser: two flops per bit, sync1 <= sw_raw, sync2 <= sync1. No other logic reads sw_raw.
- Per-bit FSM, two states, all transitions on the rising edge of clk:
  - STABLE: if sync2[i] == sw_db[i], stay, cnt = 0. If they differ, go to PENDING, cnt = 1.
  - PENDING, sync2[i] == sw_db[i]: glitch rejected. Go to STABLE, cnt = 0, no pulse.
  - PENDING, sync2[i] != sw_db[i] and cnt == DEBOUNCE_CYCLES-1: sw_db[i] <= sync2[i]. Assert sw_rise[i] or sw_fall[i] for exactly that following cycle. Go to STABLE, cnt = 0.
  - PENDING, otherwise: cnt <= cnt + 1.
- Latency:
  - sw_db[i] updates on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw level. The raw level must be held throughout.
  - Pulses are registered, high for one cycle, and coincide with the sw_db update.
- Any return to the old level while PENDING fully restarts the count; partial counts are never accumulated.
- sw_change is registered and asserted in the same cycle as any sw_rise/sw_fall bit. It is a single pulse even if several bits change together.
- Bits are fully independent. Simultaneous events on different bits each produce their own pulse in the same cycle.
- A switch held high through reset release debounces up normally: sw_db goes 1 after DEBOUNCE_CYCLES+2 edges and a sw_rise pulse is emitted.
- Reset mid-count discards all pending state. The count restarts from 0 after release.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Decomposition:
- Package de10_io_pkg holds:
  - SW_WIDTH = 10
  - CLK_HZ = 50000000
  - DEBOUNCE_10MS = 500000
  - the bit-state typedef: enum {STABLE, PENDING}
- Sub-module debounce_bit: one synchroniser, one FSM, one counter, one rise/fall pulse pair. Instantiated WIDTH times by a generate loop.
- Top level adds only the sw_change OR-reduce register.

Test Plan (WIDTH=10, DEBOUNCE_CYCLES=4):
- Reset with sw_raw=10'h3FF -> all outputs 0 while rst_n=0. After release: sw_db=10'h3FF on the 6th edge, sw_rise=10'h3FF for one cycle, sw_change=1 for one cycle.
- From all-zero, sw_raw[0] 0->1 and held -> sw_db=10'h001 on the 6th edge after first sample. sw_rise[0] pulses once. All other bits and sw_fall stay 0.
- sw_raw[1] high for exactly 3 sampled cycles, then low -> sw_db[1] stays 0. No sw_rise, no sw_fall, no sw_change at any time.
- sw_raw[2] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> sw_db[2] rises 6 edges after the final 0->1 is sampled. Exactly one sw_rise[2] pulse.
- With sw_db=10'h001, set sw_raw=10'h200 in one cycle -> sw_fall[0] and sw_rise[9] pulse in the same cycle, sw_change pulses once, sw_db=10'h200.
- sw_raw[3] 0->1, pull rst_n low when its counter reaches 2 -> outputs clear immediately without a clock edge. After release with sw_raw[3] still 1, sw_db[3] rises 6 edges later.
